clct_busy_mask_gen: RTL
=======================

# clct_busy_mask_gen

Generates the busy flags and half-strip busy mask that the 1-of-5 best-CLCT selector consumes on its second search pass. The block takes the first CLCT's packed sub-key, which carries key half-strip and quarter-strip bits. It decodes the sub-key and marks a ±separation window of half-strips as busy, then holds that window for a programmable number of clocks. It sits between first-CLCT selection and the second-CLCT search and drives the `bsy0..bsy4` group inputs.

## Interface
Parameters:
- `MXHS`, 160, number of key half-strips covered (5 groups).
- `MXGRP`, 5, number of key groups; one busy flag per group.
- `GRPW`, 32, half-strips per group; group index = key[7:5].
- `MXXKYB`, 10, sub-key width: {key[7:0], qs[1:0]}.

Ports:
- `clock`  in  1  main clock.
- `global_reset`  in  1  asynchronous, active-high reset.
- `clct0_vf`  in  1  first-CLCT valid strobe, one cycle.
- `clct0_subkey`  in  10  packed sub-key; key = [9:2], quarter-strip = [1:0].
- `clct_sep`  in  8  half-strip separation; window is key±clct_sep.
- `busy_hold`  in  4  extra hold clocks; busy lasts busy_hold+1 clocks.
- `grp_bsy`  out  5  per-group busy, bit g drives bsy<g>.
- `hs_busy`  out  160  per-half-strip busy mask.
- `busy_active`  out  1  window currently asserted.
- `busy_key`  out  8  decoded key of the active window; 0 when idle.
- `err_key_range`  out  1  sticky; set when a strobed key ≥ MXHS.

## Operation
- Reset values: `grp_bsy`=0, `hs_busy`=0, `busy_active`=0, `busy_key`=0, `err_key_range`=0. FSM=IDLE, counter=0, stage-1 registers=0.
- Stage 1, registered on each edge:
  - `s1_vf` = `clct0_vf` && key<MXHS.
  - If `clct0_vf` && key≥MXHS: strobe dropped, `err_key_range` set (sticky until reset).
  - On accept, the stage latches `s1_key`, `s1_lo` and `s1_hi`.
  - `s1_lo` = max(key−clct_sep, 0), computed as 9-bit signed.
  - `s1_hi` = min(key+clct_sep, MXHS−1), computed as 9-bit unsigned.
  - The quarter-strip bits are decoded but do not widen the window.
- Stage 2 FSM:
  - IDLE: on `s1_vf`, load window registers and set cnt=`busy_hold`, then go to HOLD.
  - HOLD with `s1_vf`: retrigger. The new window replaces the old one (latest wins, no union) and cnt reloads.
  - HOLD without `s1_vf`: if cnt==0, go to IDLE and clear the window; otherwise cnt−1.
- Outputs, registered from the window registers:
  - `hs_busy[i]` = HOLD && lo≤i≤hi.
  - `grp_bsy[g]` = OR of hs_busy[32g+31:32g].
  - `busy_active` = HOLD.
  - `busy_key` = window key in HOLD, else 0.
- `clct_sep`=0 gives a single half-strip. `clct_sep`≥MXHS clamps to the full range, so all groups go busy.
- `clct_sep` and `busy_hold` are sampled in the same cycle as the accepted strobe. Later changes do not affect an active window.

## Timing
- Latency: `clct0_vf` high at edge N leads to outputs valid after edge N+2.
- Busy duration: busy_hold+1 consecutive clocks, measured from the first edge where outputs assert.
- Retrigger at stage 1 in the last HOLD cycle gives no gap: outputs stay high and switch to the new window on the same edge.
- A strobe every cycle keeps HOLD indefinitely, with the window tracking each new key two clocks later.
- Reset asserted mid-HOLD clears all outputs asynchronously. An in-flight stage-1 strobe is lost. After deassertion, the first possible assertion is 2 edges after the next strobe.
- An out-of-range strobe during HOLD does not retrigger, and the current window continues.

## Test plan
- Subkey {40,2'b01}, sep=4, hold=0, after reset → at N+2: hs_busy[36..44]=1, all other bits 0; grp_bsy=5'b00010; busy_key=40. All outputs 0 at N+3.
- Key 30, sep=4, hold=3 → hs_busy[26..34], grp_bsy=5'b00011, held exactly 4 clocks, then 0.
- Clamping:
  - key 2, sep=5 → hs_busy[0..7], grp_bsy=5'b00001.
  - key 158, sep=4 → hs_busy[154..159], grp_bsy=5'b10000.
  - sep=255 → hs_busy all 1, grp_bsy=5'b11111.
- Key 200 strobe → err_key_range=1 from N+1 onward, no busy asserted. A second in-range strobe works normally, and err stays 1 until reset.
- Retrigger: key 40, hold=5, then key 100 three clocks later → window switches to 96..104 (grp 5'b01000) with no gap. Busy ends 6 clocks after the switch.
- Reset pulse during HOLD with hold=9 → all outputs 0 immediately. A strobe after release asserts at N+2 with the full duration.

Source files
------------

// File: rtl/clct_busy_mask_gen_if.sv
// rtl/clct_busy_mask_gen_if.sv - strobe, window settings and busy outputs of clct_busy_mask_gen
//
// master: first-CLCT strobe source; drives clct0_vf, clct0_subkey, clct_sep,
//         busy_hold and receives the busy outputs.
// slave:  the busy mask generator.
//   clct0_vf       first-CLCT valid strobe, one cycle
//   clct0_subkey   {key[7:0], qs[1:0]}
//   clct_sep       half-strip separation, window is key +/- clct_sep
//   busy_hold      extra hold clocks, busy lasts busy_hold+1 clocks
//   grp_bsy        per-group busy (bit g -> bsy<g>)
//   hs_busy        per-half-strip busy mask
//   busy_active    window asserted
//   busy_key       key of the active window, 0 when idle
//   err_key_range  sticky out-of-range key flag
interface clct_busy_mask_gen_if #(
  parameter int MXHS   = 160,
  parameter int MXGRP  = 5,
  parameter int MXXKYB = 10
);
  logic              clct0_vf;
  logic [MXXKYB-1:0] clct0_subkey;
  logic [7:0]        clct_sep;
  logic [3:0]        busy_hold;
  logic [MXGRP-1:0]  grp_bsy;
  logic [MXHS-1:0]   hs_busy;
  logic              busy_active;
  logic [7:0]        busy_key;
  logic              err_key_range;

  modport master (
    output clct0_vf, clct0_subkey, clct_sep, busy_hold,
    input  grp_bsy, hs_busy, busy_active, busy_key, err_key_range
  );

  modport slave (
    input  clct0_vf, clct0_subkey, clct_sep, busy_hold,
    output grp_bsy, hs_busy, busy_active, busy_key, err_key_range
  );
endinterface

// File: rtl/clct_busy_mask_gen.sv
// rtl/clct_busy_mask_gen.sv - busy flags and half-strip busy mask for the second CLCT search
//
// Ports:
//   clock         main clock
//   global_reset  asynchronous active-high reset
//   bus           clct_busy_mask_gen_if.slave (strobe/settings in, busy outputs out)
//
// Pipeline: stage 1 decodes/clamps the window, stage 2 FSM holds it,
// output registers expand it to the half-strip mask. Strobe at edge N
// gives outputs after edge N+2.
module clct_busy_mask_gen #(
  parameter int MXHS   = 160,
  parameter int MXGRP  = 5,
  parameter int GRPW   = 32,
  parameter int MXXKYB = 10
) (
  input  logic                  clock,
  input  logic                  global_reset,
  clct_busy_mask_gen_if.slave   bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  // Stage 1 decode. Quarter-strip bits [1:0] never widen the window, so
  // only the key field is taken from the sub-key.
  logic [7:0]        key;
  logic              key_ok;
  logic signed [8:0] lo_diff;
  logic [8:0]        hi_sum;
  logic [8:0]        lo_clamp;
  logic [8:0]        hi_clamp;

  assign key      = bus.clct0_subkey[MXXKYB-1:2];
  assign key_ok   = ({1'b0, key} < 9'(MXHS));
  assign lo_diff  = $signed({1'b0, key}) - $signed({1'b0, bus.clct_sep});
  assign hi_sum   = {1'b0, key} + {1'b0, bus.clct_sep};
  assign lo_clamp = lo_diff[8] ? 9'd0 : $unsigned(lo_diff);
  assign hi_clamp = (hi_sum > 9'(MXHS - 1)) ? 9'(MXHS - 1) : hi_sum;

  logic       s1_vf;
  logic [7:0] s1_key;
  logic [8:0] s1_lo;
  logic [8:0] s1_hi;
  logic [3:0] s1_hold;
  logic       err_q;

  // busy_hold is captured with the strobe so later changes leave an
  // already accepted window alone.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      s1_vf   <= 1'b0;
      s1_key  <= '0;
      s1_lo   <= '0;
      s1_hi   <= '0;
      s1_hold <= '0;
      err_q   <= 1'b0;
    end else begin
      s1_vf <= bus.clct0_vf && key_ok;
      if (bus.clct0_vf && key_ok) begin
        s1_key  <= key;
        s1_lo   <= lo_clamp;
        s1_hi   <= hi_clamp;
        s1_hold <= bus.busy_hold;
      end
      if (bus.clct0_vf && !key_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  // Stage 2: hold FSM. A new accepted strobe always replaces the window.
  state_t     state;
  logic [3:0] cnt;
  logic [7:0] w_key;
  logic [8:0] w_lo;
  logic [8:0] w_hi;

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state <= IDLE;
      cnt   <= '0;
      w_key <= '0;
      w_lo  <= '0;
      w_hi  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s1_vf) begin
            state <= HOLD;
            cnt   <= s1_hold;
            w_key <= s1_key;
            w_lo  <= s1_lo;
            w_hi  <= s1_hi;
          end
        end
        HOLD: begin
          if (s1_vf) begin
            cnt   <= s1_hold;
            w_key <= s1_key;
            w_lo  <= s1_lo;
            w_hi  <= s1_hi;
          end else if (cnt == 4'd0) begin
            state <= IDLE;
            w_key <= '0;
            w_lo  <= '0;
            w_hi  <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Window expansion feeding the output registers.
  logic [MXHS-1:0]  mask_next;
  logic [MXGRP-1:0] grp_next;

  always_comb begin
    mask_next = '0;
    for (int i = 0; i < MXHS; i++) begin
      mask_next[i] = (state == HOLD) && (w_lo <= 9'(i)) && (9'(i) <= w_hi);
    end
  end

  always_comb begin
    grp_next = '0;
    for (int g = 0; g < MXGRP; g++) begin
      grp_next[g] = |mask_next[g*GRPW +: GRPW];
    end
  end

  logic [MXHS-1:0]  hs_q;
  logic [MXGRP-1:0] grp_q;
  logic             active_q;
  logic [7:0]       key_q;

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      hs_q     <= '0;
      grp_q    <= '0;
      active_q <= 1'b0;
      key_q    <= '0;
    end else begin
      hs_q     <= mask_next;
      grp_q    <= grp_next;
      active_q <= (state == HOLD);
      key_q    <= (state == HOLD) ? w_key : 8'd0;
    end
  end

  assign bus.hs_busy       = hs_q;
  assign bus.grp_bsy       = grp_q;
  assign bus.busy_active   = active_q;
  assign bus.busy_key      = key_q;
  assign bus.err_key_range = err_q;

endmodule
